addsub_rr_scheduler: RTL and testbench

ADDSUB_RR_SCHEDULER -- requirements
Module: addsub_rr_scheduler

---
 rtl/addsub_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : addsub_rr_scheduler (with helper double_addsub)
// Brief    : Round-robin scheduler sharing one signed add/sub unit between
//            NREQ requesters, with a one-entry registered result stage.
// Revision : 1.0 - initial release
// ============================================================================

module double_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_a,
    input  logic             neg_b,
    output logic [WIDTH-1:0] o
);
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_a = neg_a ? (~a + 1'b1) : a;
    assign w_b = neg_b ? (~b + 1'b1) : b;
    assign o   = w_a + w_b;
endmodule

module addsub_rr_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    localparam int c_ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_neg_a,
    input  logic [NREQ-1:0]       req_neg_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_o,
    output logic [c_ID_W-1:0]     out_id
);
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [WIDTH-1:0]    r_out_o;
    logic [c_ID_W-1:0]   r_out_id;

    logic                w_accept;
    logic                w_grant_found;
    logic [c_ID_W-1:0]   w_grant_idx;
    logic [c_ID_W:0]     w_sum;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;
    logic                w_sel_neg_a;
    logic                w_sel_neg_b;
    logic [WIDTH-1:0]    w_result;
    logic [c_ID_W-1:0]   w_ptr_next;

    assign w_accept = (r_state == EMPTY) | out_ready;

    // Scan upward from r_ptr, wrapping; the first asserted request wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_sum         = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W+1)'(k);
            if (w_sum >= (c_ID_W+1)'(NREQ)) begin
                w_sum = w_sum - (c_ID_W+1)'(NREQ);
            end
            if (!w_grant_found && req_valid[w_sum[c_ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_sum[c_ID_W-1:0];
            end
        end
    end

    assign w_xfer    = w_accept & w_grant_found;
    assign req_ready = w_xfer ? (NREQ'(1) << w_grant_idx) : '0;

    assign w_sel_a     = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_sel_b     = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_sel_neg_a = req_neg_a[w_grant_idx];
    assign w_sel_neg_b = req_neg_b[w_grant_idx];

    assign w_ptr_next = (w_grant_idx == c_ID_W'(NREQ-1)) ? '0 : (w_grant_idx + 1'b1);

    double_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (w_sel_a),
        .b     (w_sel_b),
        .neg_a (w_sel_neg_a),
        .neg_b (w_sel_neg_b),
        .o     (w_result)
    );

    // A transfer always refills the stage, even when the old result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_ptr    <= '0;
            r_out_o  <= '0;
            r_out_id <= '0;
        end else begin
            if (w_xfer) begin
                r_state  <= FULL;
                r_out_o  <= w_result;
                r_out_id <= w_grant_idx;
                r_ptr    <= w_ptr_next;
            end else if (out_ready) begin
                r_state  <= EMPTY;
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_o     = r_out_o;
    assign out_id    = r_out_id;
endmodule

`default_nettype wire

// File: tb/tb_addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_rr_scheduler
// Brief    : Scoreboard bench for addsub_rr_scheduler with a reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_addsub_rr_scheduler;
    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_neg_a = '0;
    logic [N-1:0]   req_neg_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_o;
    logic [1:0]     out_id;

    addsub_rr_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_neg_a (req_neg_a),
        .req_neg_b (req_neg_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_o     (out_o),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        int           id;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_ptr  = 0;
    bit   m_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic na, input logic nb);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_neg_a[i]    = na;
        req_neg_b[i]    = nb;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N; i++) begin
            set_req(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    // One clock cycle: predict handshakes from the model, then advance it.
    task automatic step(input logic [N-1:0] v, input logic ordy);
        bit     acc;
        int     g;
        int     j;
        longint sa;
        longint sb;
        exp_t   e;
        logic [N-1:0] exp_rdy;
        req_valid = v;
        out_ready = ordy;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_full));
        acc = !m_full || out_ready;
        g   = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        exp_rdy = (acc && g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (acc && g >= 0) begin
            sa   = longint'(req_a[g*W +: W]);
            sb   = longint'(req_b[g*W +: W]);
            if (req_neg_a[g]) sa = -sa;
            if (req_neg_b[g]) sb = -sb;
            e.o  = W'((sa + sb) % (longint'(1) << W));
            e.id = g;
        end
        @(posedge clk);
        if (acc && g >= 0) begin
            q.push_back(e);
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (ordy) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    // Monitor: the head of the queue must be presented whenever out_valid is high.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got out_o=0x%0h id=%0d with empty queue", out_o, out_id);
            end else begin
                chk("out_o", 64'(out_o), 64'(q[0].o));
                chk("out_id", 64'(out_id), 64'(q[0].id));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_o", 64'(out_o), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 10; c++) step('0, 1'($urandom));

        // Requester 2: 5 - 3
        set_req(2, 16'h0005, 16'h0003, 1'b0, 1'b1);
        step(4'b0100, 1'b1);
        chk("s34_valid", 64'(out_valid), 64'd1);
        chk("s34_o", 64'(out_o), 64'h0002);
        chk("s34_id", 64'(out_id), 64'd2);
        step('0, 1'b1);

        // Negation and wrap corner cases
        set_req(0, 16'h0001, 16'h0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1);
        chk("s37_neg", 64'(out_o), 64'hFFFE);
        set_req(1, 16'h8000, 16'h8000, 1'b0, 1'b0);
        step(4'b0010, 1'b1);
        chk("s37_wrap", 64'(out_o), 64'h0000);
        step('0, 1'b1);

        // All requesters continuously valid, ptr currently at 2
        for (int c = 0; c < 6; c++) begin
            randomize_operands();
            step(4'b1111, 1'b1);
        end

        // Backpressure: stall with all valid, operands churning
        randomize_operands();
        step(4'b1111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            randomize_operands();
            step(4'b1111, 1'b0);
        end
        randomize_operands();
        step(4'b1111, 1'b1);
        chk("s36_stay_full", 64'(out_valid), 64'd1);
        step('0, 1'b1);

        // Reset while holding a result
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("s38_valid_cleared", 64'(out_valid), 64'd0);
        chk("s38_o_cleared", 64'(out_o), 64'd0);
        q.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        randomize_operands();
        step(4'b1010, 1'b1);
        chk("s38_first_grant", 64'(out_id), 64'd1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            randomize_operands();
            step(N'($urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        // Drain
        for (int c = 0; c < 3; c++) step('0, 1'b1);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
